// File: rtl/serial_tx_block.sv
// serial_tx_block: UART-style framer that shifts one parallel word out as start, data (LSB first) and stop bits
module serial_tx_block #(
    parameter int BIT_PERIOD    = 10,
    parameter int NUM_DATA_BITS = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     tx_start,
    input  logic [NUM_DATA_BITS-1:0] tx_data,
    output logic                     serial_out,
    output logic                     tx_busy,
    output logic                     tx_done
);
    localparam int CW = $clog2(BIT_PERIOD);
    localparam int IW = NUM_DATA_BITS > 1 ? $clog2(NUM_DATA_BITS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BIT_PERIOD - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

    state_t                   state;
    logic [CW-1:0]            cnt;
    logic [IW-1:0]            idx;
    logic [NUM_DATA_BITS-1:0] shift_reg;
    logic                     bit_end;
    logic [NUM_DATA_BITS-1:0] shift_nxt;

    assign bit_end   = cnt == LAST_CNT;
    assign shift_nxt = shift_reg >> 1;

    // Frame sequencer: outputs are registered one state ahead so each level lines up with its bit slot
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shift_reg  <= '0;
            serial_out <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            cnt <= (state == IDLE || state == DONE || bit_end) ? '0 : cnt + 1'b1;
            case (state)
                IDLE: if (tx_start) begin
                    state      <= START;
                    shift_reg  <= tx_data;
                    idx        <= '0;
                    serial_out <= 1'b0;
                    tx_busy    <= 1'b1;
                end
                START: if (bit_end) begin
                    state      <= DATA;
                    serial_out <= shift_reg[0];
                end
                DATA: if (bit_end) begin
                    shift_reg <= shift_nxt;
                    if (idx == LAST_IDX) begin
                        state      <= STOP;
                        serial_out <= 1'b1;
                    end else begin
                        idx        <= idx + 1'b1;
                        serial_out <= shift_nxt[0];
                    end
                end
                STOP: if (bit_end) begin
                    state   <= DONE;
                    tx_busy <= 1'b0;
                    tx_done <= 1'b1;
                end
                DONE: begin
                    state   <= IDLE;
                    tx_done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_tx_block.sv
// tb_serial_tx_block: scoreboard bench comparing per-clock {serial_out,tx_busy,tx_done} against a frame model
module tb_serial_tx_block;
    localparam int N = 8;

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       so4, busy4, done4;
    logic       so3, busy3, done3;
    logic [2:0] q[$];
    bit         sel = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    serial_tx_block #(.BIT_PERIOD(4), .NUM_DATA_BITS(N)) dut (
        .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_data(tx_data),
        .serial_out(so4), .tx_busy(busy4), .tx_done(done4)
    );

    serial_tx_block #(.BIT_PERIOD(3), .NUM_DATA_BITS(N)) dut3 (
        .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_data(tx_data),
        .serial_out(so3), .tx_busy(busy3), .tx_done(done3)
    );

    function automatic logic [2:0] obs();
        return sel ? {so3, busy3, done3} : {so4, busy4, done4};
    endfunction

    task automatic check(input string tag, input logic [2:0] o, input logic [2:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s: observed=%b expected=%b (serial_out,tx_busy,tx_done)", tag, o, e);
        end
    endtask

    // expected per-clock outputs starting with the clock right after the accept edge
    task automatic push_frame(input logic [7:0] d, input int idle);
        int bp;
        bp = sel ? 3 : 4;
        for (int j = 0; j <= (N + 2) * bp; j++) begin
            if (j < bp) q.push_back(3'b010);
            else if (j < (N + 1) * bp) q.push_back({d[j / bp - 1], 2'b10});
            else if (j < (N + 2) * bp) q.push_back(3'b110);
            else q.push_back(3'b101);
        end
        repeat (idle) q.push_back(3'b100);
    endtask

    task automatic drain(input string tag, input int n);
        repeat (n) begin
            @(negedge clk);
            if (q.size() == 0) check({tag, "_underflow"}, obs(), 3'bxxx);
            else check(tag, obs(), q.pop_front());
        end
    endtask

    task automatic send(input string tag, input logic [7:0] d, input int idle);
        @(negedge clk);
        tx_start = 1'b1;
        tx_data  = d;
        push_frame(d, idle);
        drain(tag, 1);
        tx_start = 1'b0;
        drain(tag, q.size());
    endtask

    initial begin
        // power-on reset applied mid-cycle
        #2 n_rst = 1'b0;
        #1 check("rst_async", obs(), 3'b100);
        sel = 1'b1;
        check("rst_async_bp3", obs(), 3'b100);
        sel = 1'b0;
        @(posedge clk);
        #1 check("rst_hold", obs(), 3'b100);
        @(negedge clk) n_rst = 1'b1;
        @(posedge clk);
        #1 check("rst_release", obs(), 3'b100);

        // single frame
        send("frame_a5", 8'hA5, 2);

        // back-to-back with tx_start held high
        @(negedge clk);
        tx_start = 1'b1;
        tx_data  = 8'h00;
        push_frame(8'h00, 1);
        push_frame(8'hFF, 2);
        drain("b2b", 1);
        tx_data = 8'hFF;
        drain("b2b", 42);
        tx_start = 1'b0;
        drain("b2b", q.size());

        // requests mid-frame and in DONE are ignored, data change has no effect
        @(negedge clk);
        tx_start = 1'b1;
        tx_data  = 8'h81;
        push_frame(8'h81, 6);
        drain("ignore", 1);
        tx_start = 1'b0;
        drain("ignore", 16);
        tx_start = 1'b1;
        tx_data  = 8'h3C;
        drain("ignore", 1);
        tx_start = 1'b0;
        drain("ignore", 23);
        tx_start = 1'b1;
        drain("ignore", 1);
        tx_start = 1'b0;
        drain("ignore", q.size());

        // reset during data bit 3
        @(negedge clk);
        tx_start = 1'b1;
        tx_data  = 8'hA5;
        push_frame(8'hA5, 0);
        drain("pre_abort", 1);
        tx_start = 1'b0;
        drain("pre_abort", 17);
        q.delete();
        #2 n_rst = 1'b0;
        #1 check("rst_mid_async", obs(), 3'b100);
        @(posedge clk);
        #1 check("rst_mid_hold", obs(), 3'b100);
        @(negedge clk) n_rst = 1'b1;
        repeat (3) q.push_back(3'b100);
        drain("post_abort_idle", 3);
        send("frame_5a", 8'h5A, 2);

        // odd bit period
        sel = 1'b1;
        send("bp3_01", 8'h01, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/serial_tx_block.md
# serial_tx_block

Parallel-to-serial UART-style transmitter that accepts one data byte on a start request and shifts it out as a framed serial bitstream. The frame is a start bit, NUM_DATA_BITS data bits LSB first, and a stop bit, with each bit held for BIT_PERIOD clocks. Bit timing and bit position are tracked by internal rollover counters. The block is the transmit end of the serial link whose receiver samples the line with the same BIT_PERIOD.

## Interface
Parameters:
- BIT_PERIOD, 10: clocks per serial bit; legal range 2..1023.
- NUM_DATA_BITS, 8: data bits per frame; legal range 1..16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- n_rst  input  1  asynchronous, active-low reset.
- tx_start  input  1  transmit request; sampled only in IDLE.
- tx_data  input  NUM_DATA_BITS  byte to send; captured on the accept edge.
- serial_out  output  1  serial line; idles high.
- tx_busy  output  1  high from the accept edge until the last stop-bit clock ends.
- tx_done  output  1  one-cycle pulse after the stop bit completes.

## Operation
- States: IDLE, START, DATA, STOP, DONE.
- IDLE:
  - serial_out=1, tx_busy=0, tx_done=0.
  - tx_start=1 at a rising edge is the accept edge: tx_data goes into the shift register, the bit-period counter clears, and the state moves to START.
- START: serial_out=0 for BIT_PERIOD clocks, then DATA.
- DATA:
  - serial_out = shift_reg[0].
  - When the bit-period counter reaches BIT_PERIOD-1, the shift register shifts right and the bit index increments.
  - After bit NUM_DATA_BITS-1 has been held for BIT_PERIOD clocks, the state moves to STOP.
- STOP: serial_out=1 for BIT_PERIOD clocks, then DONE.
- DONE: tx_done=1, tx_busy=0, serial_out=1 for exactly one clock, then IDLE unconditionally. tx_start is ignored in DONE.
- Counters:
  - Bit-period counter is $clog2(BIT_PERIOD) bits wide. It counts 0..BIT_PERIOD-1 and wraps to 0 on the same edge the bit advances.
  - Bit-index counter counts 0..NUM_DATA_BITS-1.
- Boundary conditions:
  - tx_start asserted in START, DATA, STOP or DONE is ignored and is not queued.
  - tx_data changes after the accept edge do not affect the frame in flight.
  - tx_start held high continuously gives back-to-back frames, each separated by exactly one DONE clock plus one IDLE clock. The accept happens at the end of that IDLE clock.
  - n_rst low at any time, including mid-frame, forces IDLE immediately (asynchronously), with serial_out=1, tx_busy=0, tx_done=0 and the counters and shift register at 0. The aborted frame is not resumed.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Timing
- Reset values: serial_out=1, tx_busy=0, tx_done=0.
- Accept edge is edge E0. The following apply after E0:
  - serial_out=0 and tx_busy=1 immediately after E0.
  - Data bit i is driven in clocks [E0+(1+i)·BIT_PERIOD, E0+(2+i)·BIT_PERIOD).
  - Stop bit is driven starting at E0+(1+NUM_DATA_BITS)·BIT_PERIOD.
  - tx_busy stays high for exactly (NUM_DATA_BITS+2)·BIT_PERIOD clocks.
  - tx_done is high for the one clock after E0+(NUM_DATA_BITS+2)·BIT_PERIOD. tx_busy is 0 in that clock.
- Minimum start-to-start spacing is (NUM_DATA_BITS+2)·BIT_PERIOD+2 clocks.
- Inputs are applied away from the rising edge. The bench drives inputs on the falling edge and checks just before the next rising edge.

## Test plan
- Power-on reset: assert n_rst=0 mid-cycle -> serial_out=1, tx_busy=0, tx_done=0 immediately; values hold across a clock; still correct after release.
- Single frame, BIT_PERIOD=4, NUM_DATA_BITS=8, tx_data=8'hA5, one-clock tx_start:
  - serial_out = 0, then 1,0,1,0,0,1,0,1, then 1, with each level held 4 clocks.
  - tx_busy high for 40 clocks.
  - tx_done pulses once, in clock 41.
- Back-to-back: tx_start held high with 8'h00 then 8'hFF -> second frame's start bit begins exactly 2 clocks after the first frame's tx_busy falls; all 8 data bits are 1.
- Ignored requests: pulse tx_start and change tx_data to 8'h3C in the middle of an 8'h81 frame -> the 8'h81 bits are unaffected and no second frame follows.
- Reset mid-frame: assert n_rst during data bit 3 -> serial_out=1 and tx_busy=0 without waiting for a clock edge. After release, a new 8'h5A frame transmits correctly from its start bit.
- Odd bit period: BIT_PERIOD=3, tx_data=8'h01 -> every bit is held exactly 3 clocks, including the last data bit and the stop bit, with no counter off-by-one at wrap.
